tile_map_writer: RTL and testbench

Command-driven writer that fills the tile-position map consumed by AudVid. It sits directly upstream of AudVid's TilesPositionAddress/TilesPositionData port. It turns single-cycle commands (write tile, horizontal run, full fill) from game/control logic into a stream of registered map writes, one per clock. After reset it clears the whole 20x15 map to tile 0.

---
 rtl/tile_map_writer.sv | 148 ++++++++++++++
 tb/tb_tile_map_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_writer.sv
// Command-driven writer for the AudVid tile-position map: clears the map after
// reset, then turns WRITE / HLINE / FILL commands into one registered write per clock.
module tile_map_writer #(
  parameter int COLS = 20,
  parameter int ROWS = 15
) (
  input  logic       MasterCLK,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [1:0] CmdOp,
  input  logic [4:0] CmdCol,
  input  logic [3:0] CmdRow,
  input  logic [4:0] CmdLen,
  input  logic [4:0] CmdTile,
  output logic       CmdError,
  output logic       Busy,
  output logic       TilesPositionWE,
  output logic [8:0] TilesPositionAddress,
  output logic [4:0] TilesPositionData
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_LINE = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_HLINE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;

  localparam logic [8:0] MAP_LAST  = 9'(COLS * ROWS - 1);
  localparam logic [4:0] COL_LIMIT = 5'(COLS);
  localparam logic [3:0] ROW_LIMIT = 4'(ROWS);

  logic [1:0] state;
  logic [8:0] counter;

  logic [8:0] row_ext;
  logic [8:0] cmd_base;
  logic       cmd_in_range;
  logic [4:0] row_room;
  logic [4:0] run_len;

  // Row*20 is built from shifts; the run is clipped so it never leaves its row.
  always_comb begin
    row_ext      = {5'd0, CmdRow};
    cmd_base     = (row_ext << 4) + (row_ext << 2) + {4'd0, CmdCol};
    cmd_in_range = (CmdCol < COL_LIMIT) && (CmdRow < ROW_LIMIT);
    row_room     = COL_LIMIT - CmdCol;
    run_len      = (CmdLen < row_room) ? CmdLen : row_room;
  end

  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      state                <= ST_INIT;
      counter              <= 9'd0;
      TilesPositionWE      <= 1'b0;
      TilesPositionAddress <= 9'd0;
      TilesPositionData    <= 5'd0;
      CmdReady             <= 1'b0;
      CmdError             <= 1'b0;
      Busy                 <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          TilesPositionWE      <= 1'b1;
          TilesPositionAddress <= counter;
          TilesPositionData    <= 5'd0;
          counter              <= counter + 9'd1;
          if (counter == MAP_LAST) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          TilesPositionWE <= 1'b0;
          CmdError        <= 1'b0;
          CmdReady        <= 1'b1;
          Busy            <= 1'b0;
          // Single-cycle commands stay in IDLE; CmdReady low blocks the next edge.
          if (CmdValid && CmdReady) begin
            CmdReady <= 1'b0;
            Busy     <= 1'b1;
            case (CmdOp)
              OP_WRITE: begin
                if (cmd_in_range) begin
                  TilesPositionWE      <= 1'b1;
                  TilesPositionAddress <= cmd_base;
                  TilesPositionData    <= CmdTile;
                end else begin
                  CmdError <= 1'b1;
                end
              end
              OP_HLINE: begin
                if (!cmd_in_range) begin
                  CmdError <= 1'b1;
                end else if (run_len != 5'd0) begin
                  TilesPositionWE      <= 1'b1;
                  TilesPositionAddress <= cmd_base;
                  TilesPositionData    <= CmdTile;
                  if (run_len > 5'd1) begin
                    state   <= ST_LINE;
                    counter <= 9'(run_len - 5'd1);
                  end
                end
              end
              OP_FILL: begin
                TilesPositionWE      <= 1'b1;
                TilesPositionAddress <= 9'd0;
                TilesPositionData    <= CmdTile;
                counter              <= 9'd1;
                state                <= ST_FILL;
              end
              default: begin
                CmdError <= 1'b1;
              end
            endcase
          end
        end

        ST_FILL: begin
          TilesPositionWE      <= 1'b1;
          TilesPositionAddress <= counter;
          counter              <= counter + 9'd1;
          if (counter == MAP_LAST) begin
            state <= ST_IDLE;
          end
        end

        ST_LINE: begin
          // counter holds the writes still owed after this one plus one.
          TilesPositionWE      <= 1'b1;
          TilesPositionAddress <= TilesPositionAddress + 9'd1;
          counter              <= counter - 9'd1;
          if (counter == 9'd1) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: table vectors, hand-written corner
// sequences and random commands against a map-level reference model.
module tb_tile_map_writer;

  logic       MasterCLK = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic       CmdReady;
  logic [1:0] CmdOp;
  logic [4:0] CmdCol;
  logic [3:0] CmdRow;
  logic [4:0] CmdLen;
  logic [4:0] CmdTile;
  logic       CmdError;
  logic       Busy;
  logic       TilesPositionWE;
  logic [8:0] TilesPositionAddress;
  logic [4:0] TilesPositionData;

  tile_map_writer dut (
    .MasterCLK            (MasterCLK),
    .Reset                (Reset),
    .CmdValid             (CmdValid),
    .CmdReady             (CmdReady),
    .CmdOp                (CmdOp),
    .CmdCol               (CmdCol),
    .CmdRow               (CmdRow),
    .CmdLen               (CmdLen),
    .CmdTile              (CmdTile),
    .CmdError             (CmdError),
    .Busy                 (Busy),
    .TilesPositionWE      (TilesPositionWE),
    .TilesPositionAddress (TilesPositionAddress),
    .TilesPositionData    (TilesPositionData)
  );

  always #5 MasterCLK = ~MasterCLK;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int op;
    int col;
    int row;
    int len;
    int tile;
    int exp_n;
    int exp_first;
    int exp_err;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  model_map [300];
  int  seen_map  [300];
  wr_t exp_q[$];
  wr_t got_q[$];
  int  exp_err;
  int  got_err;
  int  got_lat;
  int  got_busy_low;
  vec_t vecs [10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: the set of map cells a command touches, from row/column arithmetic.
  function automatic void modelCommand(input int op, input int col, input int row,
                                       input int len, input int tile);
    wr_t w;
    exp_q.delete();
    exp_err = 0;
    if (op == 0) begin
      if (col < 20 && row < 15) begin
        w.addr = row * 20 + col; w.data = tile; exp_q.push_back(w);
      end else exp_err = 1;
    end else if (op == 1) begin
      if (col < 20 && row < 15) begin
        for (int c = col; c < col + len && c < 20; c++) begin
          w.addr = row * 20 + c; w.data = tile; exp_q.push_back(w);
        end
      end else exp_err = 1;
    end else if (op == 2) begin
      for (int a = 0; a < 300; a++) begin
        w.addr = a; w.data = tile; exp_q.push_back(w);
      end
    end else exp_err = 1;
    foreach (exp_q[i]) model_map[exp_q[i].addr] = exp_q[i].data;
  endfunction

  // Called at a negedge; returns at the negedge where CmdReady is back.
  task automatic applyStimulus(input int op, input int col, input int row,
                               input int len, input int tile);
    wr_t w;
    int  wait_cnt = 0;
    got_q.delete();
    got_err = 0;
    got_lat = 0;
    got_busy_low = 0;
    while (!CmdReady && wait_cnt < 1000) begin
      @(negedge MasterCLK);
      wait_cnt++;
    end
    if (!CmdReady) begin
      checkOutput("ready_wait_timeout", 0, 1);
      return;
    end
    CmdOp = 2'(op); CmdCol = 5'(col); CmdRow = 4'(row); CmdLen = 5'(len); CmdTile = 5'(tile);
    CmdValid = 1'b1;
    @(negedge MasterCLK);
    CmdValid = 1'b0;
    CmdOp = 2'($urandom); CmdCol = 5'($urandom); CmdRow = 4'($urandom);
    CmdLen = 5'($urandom); CmdTile = 5'($urandom);
    while (!CmdReady && got_lat < 400) begin
      if (TilesPositionWE) begin
        w.addr = int'(TilesPositionAddress); w.data = int'(TilesPositionData);
        got_q.push_back(w);
        if (w.addr < 300) seen_map[w.addr] = w.data;
      end
      if (CmdError) got_err++;
      if (!Busy) got_busy_low++;
      got_lat++;
      @(negedge MasterCLK);
      CmdTile = 5'($urandom);
    end
    checkOutput("ready_returned", int'(CmdReady), 1);
    checkOutput("idle_we", int'(TilesPositionWE), 0);
    checkOutput("idle_busy", int'(Busy), 0);
  endtask

  task automatic checkCommand(input string tag, input int op, input int col, input int row,
                              input int len, input int tile);
    int bad = 0;
    int n;
    modelCommand(op, col, row, len, tile);
    applyStimulus(op, col, row, len, tile);
    n = exp_q.size();
    checkOutput({tag, "_nwrites"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) bad++;
    checkOutput({tag, "_write_content_errs"}, bad, 0);
    checkOutput({tag, "_error_pulses"}, got_err, exp_err);
    checkOutput({tag, "_latency"}, got_lat, (n > 0) ? n : 1);
    checkOutput({tag, "_busy_low_cycles"}, got_busy_low, 0);
  endtask

  // Releases reset from a negedge and follows the whole clear sequence.
  task automatic checkInit(input string tag);
    int n = 0, bad = 0, gaps = 0, guard = 0;
    Reset = 1'b1;
    for (int a = 0; a < 300; a++) model_map[a] = 0;
    while (guard < 400) begin
      @(negedge MasterCLK);
      guard++;
      if (CmdReady) break;
      if (TilesPositionWE) begin
        if (int'(TilesPositionAddress) != n || TilesPositionData != 5'd0) bad++;
        if (TilesPositionAddress < 9'd300) seen_map[TilesPositionAddress] = 0;
        n++;
      end else gaps++;
      if (!Busy) bad++;
    end
    checkOutput({tag, "_ready"}, int'(CmdReady), 1);
    checkOutput({tag, "_nwrites"}, n, 300);
    checkOutput({tag, "_order_errs"}, bad, 0);
    checkOutput({tag, "_gaps"}, gaps, 0);
    checkOutput({tag, "_we_after"}, int'(TilesPositionWE), 0);
    checkOutput({tag, "_busy_after"}, int'(Busy), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we"}, int'(TilesPositionWE), 0);
    checkOutput({tag, "_addr"}, int'(TilesPositionAddress), 0);
    checkOutput({tag, "_data"}, int'(TilesPositionData), 0);
    checkOutput({tag, "_ready"}, int'(CmdReady), 0);
    checkOutput({tag, "_error"}, int'(CmdError), 0);
    checkOutput({tag, "_busy"}, int'(Busy), 1);
  endtask

  initial begin
    int cnt, bad, guard, fills, idx, n_b2b, mism;
    int acc_cyc[$];
    wr_t w;
    wr_t b2b_q[$];
    wr_t b2b_got[$];

    vecs[0] = '{0, 19, 14,  0,  7,  1, 299, 0};
    vecs[1] = '{1, 17,  2, 10,  3,  3,  57, 0};
    vecs[2] = '{1,  5,  5,  0,  9,  0,   0, 0};
    vecs[3] = '{0, 20,  0,  0,  4,  0,   0, 1};
    vecs[4] = '{3,  0,  0,  0,  5,  0,   0, 1};
    vecs[5] = '{0,  0, 15,  0,  1,  0,   0, 1};
    vecs[6] = '{1,  0,  0, 31, 12, 20,   0, 0};
    vecs[7] = '{1, 21,  3,  4,  2,  0,   0, 1};
    vecs[8] = '{0,  0,  0,  0, 30,  1,   0, 0};
    vecs[9] = '{1, 19, 14,  1,  6,  1, 299, 0};

    Reset = 1'b0; CmdValid = 1'b0;
    CmdOp = '0; CmdCol = '0; CmdRow = '0; CmdLen = '0; CmdTile = '0;
    for (int a = 0; a < 300; a++) begin model_map[a] = 0; seen_map[a] = -1; end

    repeat (3) @(negedge MasterCLK);
    checkResetOutputs("reset");
    checkInit("init");

    for (int v = 0; v < 10; v++) begin
      checkCommand($sformatf("vec%0d", v), vecs[v].op, vecs[v].col, vecs[v].row,
                   vecs[v].len, vecs[v].tile);
      checkOutput($sformatf("vec%0d_table_n", v), got_q.size(), vecs[v].exp_n);
      checkOutput($sformatf("vec%0d_table_err", v), got_err, vecs[v].exp_err);
      if (vecs[v].exp_n > 0 && got_q.size() > 0)
        checkOutput($sformatf("vec%0d_table_first", v), got_q[0].addr, vecs[v].exp_first);
    end

    // FILL interrupted by reset half-way, then a fresh clear sequence.
    modelCommand(2, 0, 0, 0, 31);
    CmdOp = 2'd2; CmdCol = 5'd3; CmdRow = 4'd4; CmdLen = 5'd0; CmdTile = 5'd31;
    CmdValid = 1'b1;
    @(negedge MasterCLK);
    CmdValid = 1'b0; CmdTile = 5'd1;
    cnt = 0; bad = 0; guard = 0;
    while (cnt < 150 && guard < 400) begin
      if (TilesPositionWE) begin
        if (int'(TilesPositionAddress) != cnt || TilesPositionData != 5'd31) bad++;
        cnt++;
      end else bad++;
      if (cnt < 150) @(negedge MasterCLK);
      guard++;
    end
    checkOutput("fill_partial_writes", cnt, 150);
    checkOutput("fill_partial_errs", bad, 0);
    Reset = 1'b0;
    @(negedge MasterCLK);
    checkResetOutputs("fill_abort");
    @(negedge MasterCLK);
    checkResetOutputs("fill_abort_hold");
    checkInit("reinit");

    checkCommand("fill31", 2, 7, 9, 3, 31);

    // CmdValid held high across a WRITE sequence; every edge that sees ready accepts.
    n_b2b = 12;
    b2b_q.delete();
    for (int i = 0; i < n_b2b; i++) begin
      w.addr = $urandom_range(0, 299); w.data = $urandom_range(0, 31);
      b2b_q.push_back(w);
      model_map[w.addr] = w.data;
    end
    idx = 0; guard = 0;
    b2b_got.delete(); acc_cyc.delete();
    CmdOp = 2'd0;
    CmdRow = 4'(b2b_q[0].addr / 20); CmdCol = 5'(b2b_q[0].addr % 20); CmdTile = 5'(b2b_q[0].data);
    CmdValid = 1'b1;
    while (guard < 200) begin
      if (TilesPositionWE) begin
        w.addr = int'(TilesPositionAddress); w.data = int'(TilesPositionData);
        b2b_got.push_back(w);
        if (w.addr < 300) seen_map[w.addr] = w.data;
      end
      if (CmdReady) begin
        if (idx == n_b2b) break;
        acc_cyc.push_back(guard);
        idx++;
      end else if (idx < n_b2b) begin
        CmdRow = 4'(b2b_q[idx].addr / 20); CmdCol = 5'(b2b_q[idx].addr % 20);
        CmdTile = 5'(b2b_q[idx].data);
      end
      @(negedge MasterCLK);
      guard++;
    end
    CmdValid = 1'b0;
    checkOutput("b2b_accepts", acc_cyc.size(), n_b2b);
    checkOutput("b2b_writes", b2b_got.size(), n_b2b);
    mism = 0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 2) mism++;
    checkOutput("b2b_spacing_errs", mism, 0);
    mism = 0;
    for (int i = 0; i < n_b2b && i < b2b_got.size(); i++)
      if (b2b_got[i].addr != b2b_q[i].addr || b2b_got[i].data != b2b_q[i].data) mism++;
    checkOutput("b2b_content_errs", mism, 0);

    fills = 0;
    for (int r = 0; r < 40; r++) begin
      int op, col, row, len, tile;
      op = $urandom_range(0, 3);
      if (op == 2) begin
        if (fills >= 2) op = 1;
        else fills++;
      end
      col  = $urandom_range(0, 23);
      row  = $urandom_range(0, 15);
      len  = $urandom_range(0, 31);
      tile = $urandom_range(0, 31);
      checkCommand($sformatf("rnd%0d_op%0d", r, op), op, col, row, len, tile);
    end

    mism = 0;
    for (int a = 0; a < 300; a++)
      if (seen_map[a] != model_map[a]) mism++;
    checkOutput("final_map_errs", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
